// File: rtl/grid_pkg.sv
// Shared colour constants and event encoding for the grid cursor controller.
package grid_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t COL_LINE     = 12'h000;
    localparam rgb_t COL_BG       = 12'h222;
    localparam rgb_t COL_CUR      = 12'h888;
    localparam rgb_t COL_MARK     = 12'h080;
    localparam rgb_t COL_CUR_MARK = 12'h0F0;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_UP,
        EV_DOWN,
        EV_LEFT,
        EV_RIGHT,
        EV_SEL
    } ev_e;

endpackage

// File: rtl/btn_debounce.sv
// Active-low button: 2-flop synchroniser, consecutive-cycle debouncer and
// one-cycle press pulse on the debounced high-to-low transition.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [1:0]    fill_q, fill_d;
    logic          arm_q, arm_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A button held through reset stays ignored until a synchronised release
    // has been seen; fill_q marks when the synchroniser holds real samples.
    always_comb begin
        sync_d  = {sync_q[0], btn_ni};
        fill_d  = {fill_q[0], 1'b1};
        arm_d   = arm_q | (fill_q[1] & sync_q[1]);
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (arm_q && (sync_q[1] != level_q)) begin
            if (cnt_q == LAST) begin
                level_d = sync_q[1];
                press_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            fill_q  <= '0;
            arm_q   <= 1'b0;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            arm_q   <= arm_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Grid cursor controller: debounced buttons move a cursor over a ROWS x COLS
// grid, select toggles per-cell marks, and each pixel gets a registered colour.
module grid_cursor_ctrl
    import grid_pkg::*;
#(
    parameter int unsigned COLS       = 3,
    parameter int unsigned ROWS       = 3,
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned WRAP       = 0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [15:0] Xpos,
    input  logic [15:0] Ypos,
    input  logic        Btn_Up,
    input  logic        Btn_Down,
    input  logic        Btn_Left,
    input  logic        Btn_Right,
    input  logic        Btn_Sel,
    output logic [3:0]  Cursor_Col,
    output logic [3:0]  Cursor_Row,
    output logic        Sel_Valid,
    output logic [3:0]  Sel_Col,
    output logic [3:0]  Sel_Row,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue
);

    localparam int unsigned CELL_W = H_RES / COLS;
    localparam int unsigned CELL_H = V_RES / ROWS;
    localparam int unsigned GRID_W = COLS * CELL_W;
    localparam int unsigned GRID_H = ROWS * CELL_H;
    localparam int unsigned NC     = ROWS * COLS;
    localparam logic [3:0]  COL_MAX = 4'(COLS - 1);
    localparam logic [3:0]  ROW_MAX = 4'(ROWS - 1);
    localparam logic [NC-1:0] ONE   = {{(NC-1){1'b0}}, 1'b1};

    logic p_up, p_down, p_left, p_right, p_sel;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up    (.clk_i(Clk), .rst_ni(Rst_n), .btn_ni(Btn_Up),    .press_o(p_up));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down  (.clk_i(Clk), .rst_ni(Rst_n), .btn_ni(Btn_Down),  .press_o(p_down));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_left  (.clk_i(Clk), .rst_ni(Rst_n), .btn_ni(Btn_Left),  .press_o(p_left));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_right (.clk_i(Clk), .rst_ni(Rst_n), .btn_ni(Btn_Right), .press_o(p_right));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sel   (.clk_i(Clk), .rst_ni(Rst_n), .btn_ni(Btn_Sel),   .press_o(p_sel));

    ev_e           ev;
    logic [3:0]    col_q, col_d, row_q, row_d;
    logic [3:0]    sel_col_q, sel_col_d, sel_row_q, sel_row_d;
    logic          sel_valid_q, sel_valid_d;
    logic [NC-1:0] mark_q, mark_d;
    rgb_t          rgb_q, rgb_d;

    always_comb begin
        ev = EV_NONE;
        if      (p_up)    ev = EV_UP;
        else if (p_down)  ev = EV_DOWN;
        else if (p_left)  ev = EV_LEFT;
        else if (p_right) ev = EV_RIGHT;
        else if (p_sel)   ev = EV_SEL;
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        mark_d      = mark_q;
        sel_valid_d = 1'b0;
        sel_col_d   = sel_col_q;
        sel_row_d   = sel_row_q;
        case (ev)
            EV_UP:    if (row_q != 4'd0)    row_d = row_q - 4'd1; else if (WRAP != 0) row_d = ROW_MAX;
            EV_DOWN:  if (row_q != ROW_MAX) row_d = row_q + 4'd1; else if (WRAP != 0) row_d = 4'd0;
            EV_LEFT:  if (col_q != 4'd0)    col_d = col_q - 4'd1; else if (WRAP != 0) col_d = COL_MAX;
            EV_RIGHT: if (col_q != COL_MAX) col_d = col_q + 4'd1; else if (WRAP != 0) col_d = 4'd0;
            EV_SEL: begin
                mark_d      = mark_q ^ (ONE << (32'(row_q) * COLS + 32'(col_q)));
                sel_valid_d = 1'b1;
                sel_col_d   = col_q;
                sel_row_d   = row_q;
            end
            default: ;
        endcase
    end

    logic [3:0] pc, pr;
    logic       on_line, in_grid, is_cur, is_mark;

    // Cell index and grid lines come from comparisons against the cell boundaries.
    always_comb begin
        pc      = 4'd0;
        pr      = 4'd0;
        on_line = 1'b0;
        for (int unsigned k = 1; k < COLS; k++) begin
            if (32'(Xpos) >= k * CELL_W) pc = pc + 4'd1;
            if (32'(Xpos) == k * CELL_W) on_line = 1'b1;
        end
        for (int unsigned k = 1; k < ROWS; k++) begin
            if (32'(Ypos) >= k * CELL_H) pr = pr + 4'd1;
            if (32'(Ypos) == k * CELL_H) on_line = 1'b1;
        end
        in_grid = (32'(Xpos) < GRID_W) && (32'(Ypos) < GRID_H);
        is_cur  = (pc == col_q) && (pr == row_q);
        is_mark = |(mark_q & (ONE << (32'(pr) * COLS + 32'(pc))));
        if (!in_grid || on_line)  rgb_d = COL_LINE;
        else if (is_cur && is_mark) rgb_d = COL_CUR_MARK;
        else if (is_cur)          rgb_d = COL_CUR;
        else if (is_mark)         rgb_d = COL_MARK;
        else                      rgb_d = COL_BG;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            col_q       <= 4'(COLS / 2);
            row_q       <= 4'(ROWS / 2);
            mark_q      <= '0;
            sel_valid_q <= 1'b0;
            sel_col_q   <= '0;
            sel_row_q   <= '0;
            rgb_q       <= COL_LINE;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            mark_q      <= mark_d;
            sel_valid_q <= sel_valid_d;
            sel_col_q   <= sel_col_d;
            sel_row_q   <= sel_row_d;
            rgb_q       <= rgb_d;
        end
    end

    assign Cursor_Col = col_q;
    assign Cursor_Row = row_q;
    assign Sel_Valid  = sel_valid_q;
    assign Sel_Col    = sel_col_q;
    assign Sel_Row    = sel_row_q;
    assign Red        = rgb_q.r;
    assign Green      = rgb_q.g;
    assign Blue       = rgb_q.b;

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Directed bench for grid_cursor_ctrl: a saturating and a wrapping instance
// share stimulus; pixel colours are checked through an expected-value queue.
module tb_grid_cursor_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [15:0] Xpos = '0, Ypos = '0;
    logic        Btn_Up = 1'b1, Btn_Down = 1'b1, Btn_Left = 1'b1, Btn_Right = 1'b1, Btn_Sel = 1'b1;

    logic [3:0] col0, row0, scol0, srow0, r0, g0, b0;
    logic [3:0] col1, row1, scol1, srow1, r1, g1, b1;
    logic       sv0, sv1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [11:0] rgb;
    } pix_exp_t;
    pix_exp_t sb[$];

    always #5 Clk = ~Clk;

    grid_cursor_ctrl #(.COLS(3), .ROWS(3), .H_RES(640), .V_RES(480), .DEB_CYCLES(4), .WRAP(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Xpos(Xpos), .Ypos(Ypos),
        .Btn_Up(Btn_Up), .Btn_Down(Btn_Down), .Btn_Left(Btn_Left), .Btn_Right(Btn_Right), .Btn_Sel(Btn_Sel),
        .Cursor_Col(col0), .Cursor_Row(row0), .Sel_Valid(sv0), .Sel_Col(scol0), .Sel_Row(srow0),
        .Red(r0), .Green(g0), .Blue(b0));

    grid_cursor_ctrl #(.COLS(3), .ROWS(3), .H_RES(640), .V_RES(480), .DEB_CYCLES(4), .WRAP(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Xpos(Xpos), .Ypos(Ypos),
        .Btn_Up(Btn_Up), .Btn_Down(Btn_Down), .Btn_Left(Btn_Left), .Btn_Right(Btn_Right), .Btn_Sel(Btn_Sel),
        .Cursor_Col(col1), .Cursor_Row(row1), .Sel_Valid(sv1), .Sel_Col(scol1), .Sel_Row(srow1),
        .Red(r1), .Green(g1), .Blue(b1));

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a pixel, queue its expected colour, and compare one cycle later.
    task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
        pix_exp_t e;
        Xpos = 16'(x);
        Ypos = 16'(y);
        sb.push_back('{tag, exp});
        step(1);
        e = sb.pop_front();
        chk(e.tag, {20'h0, r0, g0, b0}, {20'h0, e.rgb});
    endtask

    // 0=up 1=down 2=left 3=right 4=sel
    task automatic press(input int which, input int hold);
        case (which)
            0: Btn_Up = 1'b0;
            1: Btn_Down = 1'b0;
            2: Btn_Left = 1'b0;
            3: Btn_Right = 1'b0;
            default: Btn_Sel = 1'b0;
        endcase
        step(hold);
        {Btn_Up, Btn_Down, Btn_Left, Btn_Right, Btn_Sel} = 5'b11111;
        step(10);
    endtask

    initial begin
        int cnt;
        int highs;

        // Reset values, with a pixel applied that would otherwise be the cursor colour.
        Xpos = 16'd300; Ypos = 16'd240;
        step(3);
        chk("rst_col", 32'(col0), 32'd1);
        chk("rst_row", 32'(row0), 32'd1);
        chk("rst_selv", 32'(sv0), 32'd0);
        chk("rst_sel", {24'h0, scol0, srow0}, 32'h0);
        chk("rst_rgb", {20'h0, r0, g0, b0}, 32'h000);
        Rst_n = 1'b1;
        step(4);

        pix("pix_cursor", 300, 240, 12'h888);
        pix("pix_vline", 213, 10, 12'h000);
        pix("pix_outside", 639, 479, 12'h000);
        pix("pix_bg", 100, 100, 12'h222);
        pix("pix_hline", 500, 320, 12'h000);

        // Long hold gives a single move; second press saturates or wraps.
        press(3, 50);
        chk("right1_w0", 32'(col0), 32'd2);
        chk("right1_w1", 32'(col1), 32'd2);
        press(3, 20);
        chk("right2_w0", 32'(col0), 32'd2);
        chk("right2_w1", 32'(col1), 32'd0);
        press(2, 20);
        chk("left_w0", 32'(col0), 32'd1);
        chk("left_wrap_w1", 32'(col1), 32'd2);

        // Bounce shorter than the debounce window is ignored.
        for (int i = 0; i < 20; i++) begin
            Btn_Up = (i % 2 == 1);
            step(2);
        end
        Btn_Up = 1'b1;
        step(4);
        chk("bounce_row", 32'(row0), 32'd1);

        Btn_Up = 1'b0;
        cnt = 0;
        while (row0 == 4'd1 && cnt < 30) begin
            step(1);
            cnt++;
        end
        chk("up_latency", 32'(cnt), 32'd7);
        chk("up_row_w0", 32'(row0), 32'd0);
        chk("up_row_w1", 32'(row1), 32'd0);
        Btn_Up = 1'b1;
        step(10);

        // Simultaneous Up+Left: only Up acts, Left is dropped.
        press(1, 20);
        chk("down_row", 32'(row0), 32'd1);
        Btn_Up = 1'b0; Btn_Left = 1'b0;
        step(30);
        chk("upleft_row", 32'(row0), 32'd0);
        chk("upleft_col_w0", 32'(col0), 32'd1);
        chk("upleft_col_w1", 32'(col1), 32'd2);
        {Btn_Up, Btn_Left} = 2'b11;
        step(10);
        press(1, 20);

        // Select at (1,1): single-cycle valid pulse and mark colours.
        Btn_Sel = 1'b0;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (sv0) begin
                highs++;
                chk("sel_cell", {24'h0, scol0, srow0}, 32'h11);
            end
        end
        chk("sel_pulses", 32'(highs), 32'd1);
        Btn_Sel = 1'b1;
        step(10);
        pix("pix_cur_mark", 300, 240, 12'h0F0);
        press(3, 20);
        pix("pix_mark", 300, 240, 12'h080);
        pix("pix_cur_col2", 500, 240, 12'h888);
        press(2, 20);
        press(4, 20);
        pix("pix_unmarked", 300, 240, 12'h888);
        press(4, 20);
        pix("pix_remarked", 300, 240, 12'h0F0);

        // Reset while Down is held: no move until release and a fresh press.
        Btn_Down = 1'b0;
        step(20);
        chk("held_down_row", 32'(row0), 32'd2);
        Rst_n = 1'b0;
        step(1);
        chk("mrst_col", 32'(col0), 32'd1);
        chk("mrst_row", 32'(row0), 32'd1);
        chk("mrst_selv", 32'(sv0), 32'd0);
        chk("mrst_rgb", {20'h0, r0, g0, b0}, 32'h000);
        Rst_n = 1'b1;
        step(30);
        chk("mrst_hold_row", 32'(row0), 32'd1);
        pix("mrst_mark_clear", 300, 240, 12'h888);
        Btn_Down = 1'b1;
        step(10);
        chk("mrst_release_row", 32'(row0), 32'd1);
        press(1, 20);
        chk("mrst_repress_row", 32'(row0), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
